dfp_addsub_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined 128-bit decimal floating-point add/sub unit (DFPAddsub128nr) among NREQ requesters. Grants at most one operation per cycle and registers its operands into the unit. Tracks each in-flight operation's requester ID in a tag pipeline matched to the unit latency. Returns results on a single valid/ready result port tagged with the requester ID, and freezes the whole pipeline through the unit's ce when the result is not accepted.

---
 rtl/dfp_pkg.sv | 24 ++
 rtl/dfp_rr_pick.sv | 36 +++
 rtl/dfp_addsub_arb.sv | 130 +++++++++++++
 tb/tb_dfp_addsub_arb.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfp_pkg.sv
// Shared types for the decimal floating-point add/sub sharing logic.
//   DFP128    : 128-bit packed decimal floating-point word
//   RM_*      : rounding-mode encodings carried to the unit on dp_rm
//   arb_tag_t : {valid, requester ID} travelling alongside each operation
package dfp_pkg;

  typedef logic [127:0] DFP128;

  localparam logic [2:0] RM_HALF_EVEN = 3'd0;  // round half to even
  localparam logic [2:0] RM_CEIL      = 3'd1;  // toward +infinity
  localparam logic [2:0] RM_FLOOR     = 3'd2;  // toward -infinity
  localparam logic [2:0] RM_TRUNC     = 3'd3;  // toward zero
  localparam logic [2:0] RM_HALF_UP   = 3'd4;  // round half away from zero

  // Sized for the largest supported requester count (8); smaller
  // configurations leave the upper ID bits at zero.
  localparam int IDW_MAX = 3;

  typedef struct packed {
    logic               v;
    logic [IDW_MAX-1:0] id;
  } arb_tag_t;

endpackage

// File: rtl/dfp_rr_pick.sv
// Round-robin priority picker.
//   req    : request vector
//   ptr    : last winner; search starts at ptr+1 (mod N) and walks upward
//   gnt    : one-hot grant, zero when no request is set
//   gnt_id : index of the granted requester (0 when none)
//   any    : at least one request is set
module dfp_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path
    // through the loop leaves a variable unassigned (no latch).
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfp_addsub_arb.sv
// Shares one pipelined 128-bit decimal add/sub unit among NREQ requesters.
// One operation per cycle is granted round-robin and registered into the
// unit; a LAT-deep tag pipeline carries the requester ID alongside it, and
// results come back on a single valid/ready port. When a result is not
// accepted, the whole pipeline (unit via dp_ce, tags, grant) freezes.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot/zero)
//   req_op/req_rm/req_a/b : per-requester operation, rounding mode, operands
//   dp_ce                 : unit clock enable (low only while stalled)
//   dp_op/dp_rm/dp_a/dp_b : registered unit inputs
//   dp_o                  : unit result
//   res_valid/res_ready   : result handshake
//   res_id/res_o          : issuing requester and result
//   busy/inflight         : operations accepted but not yet returned
//
// Timing notes: res_ready -> dp_ce and res_ready -> req_ready are
// combinational, as is req_valid -> req_ready.
module dfp_addsub_arb
  import dfp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 20,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ-1:0][2:0]      req_rm,
  input  DFP128 [NREQ-1:0]          req_a,
  input  DFP128 [NREQ-1:0]          req_b,
  output logic                      dp_ce,
  output logic                      dp_op,
  output logic [2:0]                dp_rm,
  output DFP128                     dp_a,
  output DFP128                     dp_b,
  input  DFP128                     dp_o,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [IDW-1:0]            res_id,
  output DFP128                     res_o,
  output logic                      busy,
  output logic [$clog2(LAT+2)-1:0]  inflight
);

  logic            stall;
  logic            accept;
  logic            res_hs;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [IDW-1:0]  ptr_q;
  arb_tag_t        tag_q [LAT];

  dfp_rr_pick #(
    .N (NREQ),
    .W (IDW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  assign stall     = res_valid & ~res_ready;
  // Enabled during reset so the unit flushes whatever it holds.
  assign dp_ce     = rst | ~stall;
  assign req_ready = (rst || stall) ? '0 : gnt;
  assign accept    = gnt_any && |(req_valid & req_ready);

  assign res_valid = tag_q[LAT-1].v;
  assign res_id    = tag_q[LAT-1].id[IDW-1:0];
  assign res_o     = dp_o;
  assign res_hs    = res_valid & res_ready;
  assign busy      = (inflight != '0);

  // Upper bits of the shared tag ID are always zero for NREQ < 8.
  logic unused_tag_id;
  assign unused_tag_id = ^tag_q[LAT-1].id;

  // Tag pipeline: shifts with the unit, holds completely while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tags are reset so in-flight results are discarded; the
      // unit's own data registers need no reset because only tagged
      // slots are ever presented as results.
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else if (!stall) begin
      // NOTE: non-blocking assignments make every stage sample the
      // pre-edge value of its predecessor, giving a true shift register.
      tag_q[0] <= accept ? arb_tag_t'{v: 1'b1, id: IDW_MAX'(gnt_id)} : '0;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Unit input registers and round-robin pointer load only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_op <= 1'b0;
      dp_rm <= RM_HALF_EVEN;
      dp_a  <= '0;
      dp_b  <= '0;
      ptr_q <= IDW'(NREQ - 1);  // requester 0 wins first
    end else if (accept) begin
      dp_op <= req_op[gnt_id];
      dp_rm <= req_rm[gnt_id];
      dp_a  <= req_a[gnt_id];
      dp_b  <= req_b[gnt_id];
      ptr_q <= gnt_id;
    end
  end

  // Occupancy equals the number of valid tags, so it cannot exceed LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, res_hs})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_dfp_addsub_arb.sv
module tb_dfp_addsub_arb;
  import dfp_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 20;
  localparam int IDW  = 2;
  localparam int CW   = $clog2(LAT + 2);

  localparam DFP128 T1_A   = 128'h3dffde00000000000000000000000000;
  localparam DFP128 T1_B   = 128'h29ffce00000000000000000000000000;
  localparam DFP128 T1_SUM = 128'h67ffac00000000000000000000000000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_op;
  logic [NREQ-1:0][2:0] req_rm;
  DFP128 [NREQ-1:0]     req_a, req_b;
  logic                 dp_ce, dp_op;
  logic [2:0]           dp_rm;
  DFP128                dp_a, dp_b, dp_o, res_o;
  logic                 res_valid, res_ready, busy;
  logic [IDW-1:0]       res_id;
  logic [CW-1:0]        inflight;

  always #5 clk = ~clk;

  dfp_addsub_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
    .dp_ce(dp_ce), .dp_op(dp_op), .dp_rm(dp_rm), .dp_a(dp_a), .dp_b(dp_b),
    .dp_o(dp_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_o(res_o), .busy(busy), .inflight(inflight)
  );

  // Datapath stub: binary add/sub through a delay line. The arbiter's dp_*
  // registers are the first of the LAT edges, so LAT-1 more stages follow.
  DFP128 st [LAT-1];
  always @(posedge clk) begin
    if (dp_ce) begin
      st[0] <= dp_op ? dp_a - dp_b : dp_a + dp_b;
      for (int i = 1; i < LAT - 1; i++) st[i] <= st[i-1];
    end
  end
  assign dp_o = st[LAT-2];

  // Edge counter and handshake logs; each entry records the edge number
  // at which the handshake completes.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    g_id[$], g_edge[$], r_id[$], r_edge[$];
  DFP128 r_o[$];
  int    peak = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        r_id.push_back(int'(res_id));
        r_o.push_back(res_o);
        r_edge.push_back(cyc + 1);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          g_id.push_back(i);
          g_edge.push_back(cyc + 1);
        end
      end
      if (int'(inflight) > peak) peak = int'(inflight);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_id.delete(); g_edge.delete();
    r_id.delete(); r_edge.delete(); r_o.delete();
    peak = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  // Steps until res_valid, bounded; returns the number of steps taken.
  task automatic wait_res(output int n);
    n = 0;
    #1;
    while (!res_valid && n < 100) begin
      step();
      #1;
      n++;
    end
    if (!res_valid) check("wait_res_timeout", 0, 1);
  endtask

  initial begin
    int n, s;
    rst = 1'b1; req_valid = '0; req_op = '0; req_rm = '0;
    req_a = '0; req_b = '0; res_ready = 1'b1;

    // Reset state, observed while reset is still asserted.
    repeat (3) step();
    req_valid = '1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_dp_ce", dp_ce, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_inflight", inflight, 0);
    check("rst_dp_a", dp_a, 0);
    req_valid = '0;
    rst = 1'b0;
    clear_logs();

    // Single operation from requester 1.
    req_a[1] = T1_A; req_b[1] = T1_B; req_op[1] = 1'b0; req_rm[1] = RM_HALF_EVEN;
    req_valid = 4'b0010;
    #1;
    check("t1_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    #1;
    check("t1_inflight1", inflight, 1);
    check("t1_dp_a", dp_a, T1_A);
    check("t1_dp_b", dp_b, T1_B);
    wait_res(n);
    check("t1_latency", n + 1, LAT);
    check("t1_res_id", res_id, 1);
    check("t1_res_o", res_o, T1_SUM);
    step();
    #1;
    check("t1_inflight0", inflight, 0);
    check("t1_res_valid0", res_valid, 0);
    check("t1_busy0", busy, 0);

    // All four requesters continuously valid: grants 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = DFP128'(100 + i); req_b[i] = DFP128'(i); req_op[i] = 1'b0;
    end
    s = cyc + 1;
    req_valid = '1;
    repeat (8) step();
    req_valid = '0;
    repeat (LAT + 2) step();
    check("t2_ngrant", g_id.size(), 8);
    check("t2_nres", r_id.size(), 8);
    for (int j = 0; j < 8 && j < g_id.size(); j++) begin
      check("t2_gnt_id", g_id[j], j % 4);
      check("t2_gnt_edge", g_edge[j], s + j);
    end
    for (int j = 0; j < 8 && j < r_id.size(); j++) begin
      check("t2_res_id", r_id[j], j % 4);
      check("t2_res_o", r_o[j], 100 + 2 * (j % 4));
      check("t2_res_edge", r_edge[j], s + j + LAT);
    end

    // Five-cycle stall with four results pending.
    do_reset();
    s = cyc + 1;
    req_valid = '1;
    repeat (4) step();
    req_valid = '0;
    while (cyc < s + LAT - 1) step();
    check("t3_first_valid", res_valid, 1);
    res_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("t3_ce", dp_ce, 0);
    check("t3_ready", req_ready, 0);
    repeat (5) begin
      step();
      #1;
      check("t3_hold_valid", res_valid, 1);
      check("t3_hold_id", res_id, 0);
      check("t3_hold_o", res_o, 100);
      check("t3_hold_ce", dp_ce, 0);
      check("t3_hold_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    req_valid = '0;
    repeat (10) step();
    check("t3_nres", r_id.size(), 4);
    for (int j = 0; j < 4 && j < r_id.size(); j++) begin
      check("t3_res_id", r_id[j], j);
      check("t3_res_edge", r_edge[j], s + LAT + 5 + j);
    end

    // Sparse requests from requester 2 every third cycle.
    do_reset();
    req_a[2] = 128'd7; req_b[2] = 128'd5; req_op[2] = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'b0100;
      #1;
      check("t4_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      step();
      step();
    end
    while (cyc < s + 27 + LAT - 1) step();
    #1;
    check("t4_busy_last", busy, 1);
    check("t4_valid_last", res_valid, 1);
    check("t4_inflight_last", inflight, 1);
    step();
    #1;
    check("t4_busy_done", busy, 0);
    check("t4_inflight_done", inflight, 0);
    check("t4_peak", peak, (LAT + 2) / 3);
    check("t4_nres", r_id.size(), 10);
    for (int j = 0; j < r_id.size(); j++) begin
      check("t4_res_id", r_id[j], 2);
      check("t4_res_o", r_o[j], 2);
    end

    // Reset with six operations in flight.
    do_reset();
    req_valid = '1;
    repeat (6) step();
    req_valid = '0;
    repeat (3) step();
    #1;
    check("t5_pre_inflight", inflight, 6);
    rst = 1'b1;
    step();
    req_valid = '1;
    #1;
    check("t5_res_valid", res_valid, 0);
    check("t5_inflight", inflight, 0);
    check("t5_busy", busy, 0);
    check("t5_ce", dp_ce, 1);
    check("t5_ready", req_ready, 0);
    req_valid = '0;
    rst = 1'b0;
    clear_logs();
    repeat (LAT + 2) step();
    check("t5_stale", r_id.size(), 0);
    req_valid = '1;
    #1;
    check("t5_first_grant", req_ready, 4'b0001);
    req_valid = '0;

    // Zero operands, subtract, rounding mode 3 from requester 3.
    req_a[3] = '0; req_b[3] = '0; req_op[3] = 1'b1; req_rm[3] = RM_TRUNC;
    req_valid = 4'b1000;
    #1;
    check("t6_ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    #1;
    check("t6_dp_rm", dp_rm, 3);
    check("t6_dp_op", dp_op, 1);
    wait_res(n);
    check("t6_latency", n + 1, LAT);
    check("t6_res_id", res_id, 3);
    check("t6_res_o", res_o, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
